frame_write_arbiter: RTL and testbench

FRAME_WRITE_ARBITER -- requirements
Module: frame_write_arbiter

---
 rtl/frame_write_arbiter_pkg.sv | 20 ++
 rtl/frame_write_arbiter_rr_arbiter.sv | 34 +++
 rtl/frame_write_arbiter.sv | 137 +++++++++++++
 tb/tb_frame_write_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_write_arbiter_pkg.sv
// Shared pixel color encoding and small sizing helpers for the frame writer.
// Pure declarations: no logic, no latency, no flow control.
package frame_write_arbiter_pkg;

    localparam int COLOR_WIDTH = 4;

    typedef logic [COLOR_WIDTH-1:0] color_t;

    localparam color_t COLOR_NONE  = 4'h0;
    localparam color_t COLOR_RED   = 4'h1;
    localparam color_t COLOR_GREEN = 4'h2;
    localparam color_t COLOR_BLUE  = 4'h3;
    localparam color_t COLOR_WHITE = 4'hF;

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_write_arbiter_rr_arbiter.sv
// Round-robin grant: one-hot pick of the first request above last_grant, wrapping at N.
// Purely combinational, zero latency; no backpressure of its own.
module rr_arbiter
    import frame_write_arbiter_pkg::*;
#(
    parameter int  N  = 3,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_grant_i,
    output logic [N-1:0]  grant_o
);

    logic found;

    // Two passes give the wrap at N without relying on power-of-two rollover.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        for (int p = 0; p < N; p++) begin
            if (!found && req_i[p] && (p > int'(last_grant_i))) begin
                grant_o[p] = 1'b1;
                found      = 1'b1;
            end
        end
        for (int p = 0; p < N; p++) begin
            if (!found && req_i[p] && (p <= int'(last_grant_i))) begin
                grant_o[p] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_write_arbiter.sv
// Arbitrates pixel writes from N_REQ requesters into one registered frame port, or sweeps the frame clear.
// Latency 1 from transfer to wr_en; ready is combinational and forced low during a clear or reset.
module frame_write_arbiter
    import frame_write_arbiter_pkg::*;
#(
    parameter int  WIDTH  = 640,
    parameter int  HEIGHT = 480,
    parameter int  N_REQ  = 3,
    localparam int XW     = idx_width(WIDTH),
    localparam int YW     = idx_width(HEIGHT),
    localparam int IW     = idx_width(N_REQ)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   clear_start,
    output logic                                   clear_busy,
    input  logic [N_REQ-1:0]                       req_valid,
    output logic [N_REQ-1:0]                       req_ready,
    input  logic [N_REQ-1:0][XW-1:0]               req_x,
    input  logic [N_REQ-1:0][YW-1:0]               req_y,
    input  logic [N_REQ-1:0][COLOR_WIDTH-1:0]      req_color,
    output logic                                   wr_en,
    output logic [XW-1:0]                          wr_x,
    output logic [YW-1:0]                          wr_y,
    output logic [COLOR_WIDTH-1:0]                 wr_color
);

    typedef enum logic {
        STATE_ARB   = 1'b0,
        STATE_CLEAR = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [XW-1:0]          cx_q, cx_d;
    logic [YW-1:0]          cy_q, cy_d;
    logic [IW-1:0]          last_grant_q, last_grant_d;
    logic                   wr_en_q, wr_en_d;
    logic [XW-1:0]          wr_x_q, wr_x_d;
    logic [YW-1:0]          wr_y_q, wr_y_d;
    logic [COLOR_WIDTH-1:0] wr_color_q, wr_color_d;
    logic [N_REQ-1:0]       grant;
    logic                   arb_open;

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    // A clear request wins the cycle it arrives, so no requester can slip in alongside it.
    assign arb_open  = reset && (state_q == STATE_ARB) && !clear_start;
    assign req_ready = arb_open ? grant : '0;

    always_comb begin
        state_d      = state_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        last_grant_d = last_grant_q;
        wr_en_d      = 1'b0;
        wr_x_d       = wr_x_q;
        wr_y_d       = wr_y_q;
        wr_color_d   = wr_color_q;

        case (state_q)
            STATE_ARB: begin
                if (clear_start) begin
                    state_d = STATE_CLEAR;
                    cx_d    = '0;
                    cy_d    = '0;
                end else if (|grant) begin
                    wr_en_d = 1'b1;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (grant[i]) begin
                            wr_x_d       = req_x[i];
                            wr_y_d       = req_y[i];
                            wr_color_d   = req_color[i];
                            last_grant_d = IW'(i);
                        end
                    end
                end
            end

            STATE_CLEAR: begin
                wr_en_d    = 1'b1;
                wr_x_d     = cx_q;
                wr_y_d     = cy_q;
                wr_color_d = COLOR_NONE;
                if (cx_q == XW'(WIDTH - 1)) begin
                    cx_d = '0;
                    if (cy_q == YW'(HEIGHT - 1)) begin
                        cy_d    = '0;
                        state_d = STATE_ARB;
                    end else begin
                        cy_d = cy_q + 1'b1;
                    end
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end

            default: begin
                state_d = STATE_ARB;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= STATE_ARB;
            cx_q         <= '0;
            cy_q         <= '0;
            last_grant_q <= IW'(N_REQ - 1);
            wr_en_q      <= 1'b0;
            wr_x_q       <= '0;
            wr_y_q       <= '0;
            wr_color_q   <= COLOR_NONE;
        end else begin
            state_q      <= state_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            last_grant_q <= last_grant_d;
            wr_en_q      <= wr_en_d;
            wr_x_q       <= wr_x_d;
            wr_y_q       <= wr_y_d;
            wr_color_q   <= wr_color_d;
        end
    end

    assign clear_busy = (state_q == STATE_CLEAR);
    assign wr_en      = wr_en_q;
    assign wr_x       = wr_x_q;
    assign wr_y       = wr_y_q;
    assign wr_color   = wr_color_q;

endmodule

// File: tb/tb_frame_write_arbiter.sv
// Scoreboard bench for frame_write_arbiter at 4x4 with three requesters.
module tb_frame_write_arbiter;
    import frame_write_arbiter_pkg::*;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int N  = 3;
    localparam int XW = 2;
    localparam int YW = 2;

    logic                             clk = 1'b0;
    logic                             reset = 1'b0;
    logic                             clear_start = 1'b0;
    logic                             clear_busy;
    logic [N-1:0]                     req_valid = '0;
    logic [N-1:0]                     req_ready;
    logic [N-1:0][XW-1:0]             req_x = '0;
    logic [N-1:0][YW-1:0]             req_y = '0;
    logic [N-1:0][COLOR_WIDTH-1:0]    req_color = '0;
    logic                             wr_en;
    logic [XW-1:0]                    wr_x;
    logic [YW-1:0]                    wr_y;
    logic [COLOR_WIDTH-1:0]           wr_color;

    frame_write_arbiter #(
        .WIDTH  (W),
        .HEIGHT (H),
        .N_REQ  (N)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_color   (req_color),
        .wr_en       (wr_en),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_color    (wr_color)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int c;
        int due;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: grant by searching upward from the last grant, sweep as a linear pixel index.
    int           m_lg    = N - 1;
    bit           m_clear = 1'b0;
    int           m_k     = 0;
    int           m_g;
    int           m_c;
    logic [N-1:0] exp_rdy;
    bit           exp_busy;

    always @(negedge clk) begin
        #1;
        exp_rdy  = '0;
        exp_busy = 1'b0;
        if (!reset) begin
            m_clear = 1'b0;
            m_lg    = N - 1;
            m_k     = 0;
            exp_q.delete();
        end else if (!m_clear) begin
            if (clear_start) begin
                m_clear = 1'b1;
                m_k     = 0;
            end else begin
                m_g = -1;
                for (int j = 1; j <= N; j++) begin
                    m_c = (m_lg + j) % N;
                    if (m_g < 0 && req_valid[m_c]) m_g = m_c;
                end
                if (m_g >= 0) begin
                    exp_rdy[m_g] = 1'b1;
                    exp_q.push_back('{x: int'(req_x[m_g]), y: int'(req_y[m_g]),
                                      c: int'(req_color[m_g]), due: cyc + 1});
                    m_lg = m_g;
                end
            end
        end else begin
            exp_busy = 1'b1;
            exp_q.push_back('{x: m_k % W, y: m_k / W, c: int'(COLOR_NONE), due: cyc + 1});
            m_k++;
            if (m_k == W * H) m_clear = 1'b0;
        end
        check("req_ready", int'(req_ready), int'(exp_rdy));
        check("clear_busy", int'(clear_busy), int'(exp_busy));
    end

    // Monitor: pops the expected write whenever the DUT presents one.
    int   hold_x = 0;
    int   hold_y = 0;
    int   hold_c = 0;
    exp_t e;

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            hold_x = 0;
            hold_y = 0;
            hold_c = int'(COLOR_NONE);
            check("reset_wr_en", int'(wr_en), 0);
        end else if (wr_en) begin
            if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got write (%0d,%0d) color %0d, expected none (cycle %0d)",
                         wr_x, wr_y, wr_color, cyc);
            end else begin
                e = exp_q.pop_front();
                check("wr_x", int'(wr_x), e.x);
                check("wr_y", int'(wr_y), e.y);
                check("wr_color", int'(wr_color), e.c);
                hold_x = e.x;
                hold_y = e.y;
                hold_c = e.c;
            end
        end else begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missed_write: got wr_en 0, expected write (%0d,%0d) (cycle %0d)", e.x, e.y, cyc);
            end
            check("hold_addr", int'({wr_x, wr_y}), hold_x * 4 + hold_y);
            check("hold_color", int'(wr_color), hold_c);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wr_en"}, int'(wr_en), 0);
        check({tag, "_wr_x"}, int'(wr_x), 0);
        check({tag, "_wr_y"}, int'(wr_y), 0);
        check({tag, "_wr_color"}, int'(wr_color), int'(COLOR_NONE));
        check({tag, "_clear_busy"}, int'(clear_busy), 0);
        check({tag, "_req_ready"}, int'(req_ready), 0);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        check_reset_values("rst");
        repeat (2) tick();
        reset = 1'b1;
    endtask

    int           cnt;
    int           wcnt;
    bit           found;
    bit           prev_busy;
    logic [N-1:0] last_rdy;

    initial begin
        repeat (2) tick();
        check_reset_values("por");
        reset = 1'b1;

        // First cycle after release: requester 0 is served, write appears a cycle later.
        req_valid    = 3'b001;
        req_x[0]     = 2'd2;
        req_y[0]     = 2'd1;
        req_color[0] = COLOR_BLUE;
        @(negedge clk);
        #2;
        check("first_grant", int'(req_ready), 1);
        tick();
        req_valid = '0;
        repeat (2) tick();

        // Rotating grant with all three requesters held valid.
        apply_reset();
        req_valid = 3'b111;
        req_x     = {2'd3, 2'd2, 2'd1};
        req_y     = {2'd0, 2'd3, 2'd2};
        req_color = {COLOR_WHITE, COLOR_GREEN, COLOR_RED};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #2;
            check("grant_order", int'(req_ready), 1 << (i % 3));
            tick();
        end
        req_valid = '0;
        repeat (3) tick();

        // Clear with idle requesters.
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            #2;
            if (clear_busy) cnt++;
        end
        check("clear_busy_cycles", cnt, W * H);
        tick();

        // Clear coincident with a pending request: requester 1 waits until the sweep ends.
        req_valid    = 3'b010;
        req_x[1]     = 2'd1;
        req_y[1]     = 2'd3;
        req_color[1] = COLOR_GREEN;
        clear_start  = 1'b1;
        tick();
        clear_start = 1'b0;
        found       = 1'b0;
        prev_busy   = 1'b1;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            #2;
            if (req_ready[1]) begin
                found = 1'b1;
                check("served_after_clear", int'(prev_busy) * 2 + int'(clear_busy), 2);
            end
            prev_busy = clear_busy;
        end
        check("served_found", int'(found), 1);
        tick();
        req_valid = '0;
        repeat (2) tick();

        // A second clear_start mid-sweep must not restart it.
        clear_start = 1'b1;
        cnt = 0;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            clear_start = (cnt == 5 && !found);
            if (clear_start) found = 1'b1;
            @(negedge clk);
            #2;
            if (clear_busy) cnt++;
        end
        clear_start = 1'b0;
        check("reclear_busy_cycles", cnt, W * H);
        tick();

        // Reset while the seventh clear write is on the port aborts the sweep.
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        wcnt = 0;
        for (int k = 0; k < 40 && wcnt < 7; k++) begin
            @(negedge clk);
            #2;
            if (wr_en) wcnt++;
        end
        check("clear_write_7_reached", wcnt, 7);
        reset = 1'b0;
        #1;
        check_reset_values("midclear");
        repeat (2) tick();
        reset = 1'b1;
        wcnt = 0;
        cnt  = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #2;
            if (wr_en) wcnt++;
            if (clear_busy) cnt++;
            tick();
        end
        check("no_resume_writes", wcnt, 0);
        check("no_resume_busy", cnt, 0);

        // Randomised traffic with occasional clears; requesters hold payload until served.
        last_rdy = '0;
        for (int k = 0; k < 500; k++) begin
            clear_start = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_rdy[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_x[i]     = 2'($urandom_range(0, W - 1));
                    req_y[i]     = 2'($urandom_range(0, H - 1));
                    req_color[i] = 4'($urandom_range(0, 15));
                end
            end
            @(negedge clk);
            #2;
            last_rdy = req_ready;
            tick();
        end
        clear_start = 1'b0;
        req_valid   = '0;
        repeat (25) tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
